alu_share_ctrl: RTL

- Shares one combinational ALU between two requesters (port 0, port 1).
- Each requester issues an opcode and two operands with a valid/ready handshake.
- The controller arbitrates round-robin, registers the operands into the ALU, and captures result and flag.
- It returns a one-cycle response to the requester that was granted, and screens out illegal operations and divide-by-zero before they reach the ALU.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/rr_arb2.sv | 38 +++
 rtl/alu_share_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag-op set and controller states for alu_share_ctrl
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_MUL  = 5'h02;
  localparam logic [4:0] OP_DIV  = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h05;
  localparam logic [4:0] OP_XOR  = 5'h06;
  localparam logic [4:0] OP_SLL  = 5'h07;
  localparam logic [4:0] OP_NOT  = 5'h08;
  localparam logic [4:0] OP_SRL  = 5'h09;
  localparam logic [4:0] OP_SRA  = 5'h0A;
  localparam logic [4:0] OP_SLT  = 5'h0B;
  localparam logic [4:0] OP_SLTU = 5'h0C;
  localparam logic [4:0] OP_INC  = 5'h0D;
  localparam logic [4:0] OP_DEC  = 5'h0E;
  localparam logic [4:0] OP_LAST = 5'h0E;

  // Bit n set means the ALU drives a meaningful flag for opcode n.
  localparam logic [31:0] FLAG_OPS = (32'd1 << OP_ADD) | (32'd1 << OP_NOT) |
                                     (32'd1 << OP_SLT) | (32'd1 << OP_SLTU);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic is_flag_op(input logic [4:0] op);
    return FLAG_OPS[op];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter owning last_grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance && (gnt != 2'b00)) begin
      last_grant_d = gnt[1];
    end
  end

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between two requesters
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_flag_q, rsp_flag_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;

  logic [1:0]       gnt;
  logic             advance;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .advance (advance),
    .gnt     (gnt)
  );

  // A grant in IDLE is the handshake: gnt is already qualified by valid.
  assign advance    = (state_q == ST_IDLE) && (gnt != 2'b00);
  assign req0_ready = (state_q == ST_IDLE) && gnt[0];
  assign req1_ready = (state_q == ST_IDLE) && gnt[1];

  assign sel_op = gnt[1] ? req1_op : req0_op;
  assign sel_a  = gnt[1] ? req1_a  : req0_a;
  assign sel_b  = gnt[1] ? req1_b  : req0_b;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    rsp_err_d    = rsp_err_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (advance) begin
          id_d      = gnt[1];
          alu_op_d  = sel_op;
          alu_in1_d = sel_a;
          alu_in2_d = sel_b;
          if (sel_op > OP_LAST) begin
            rsp_result_d = '0;
            rsp_flag_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end else if ((sel_op == OP_DIV) && (sel_b == '0)) begin
            rsp_result_d = '1;
            rsp_flag_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        // The ALU leaves its flag undriven for ops outside FLAG_OPS.
        rsp_flag_d   = is_flag_op(alu_op_q) && alu_flag;
        rsp_err_d    = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid_d = !id_q;
        rsp1_valid_d = id_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      id_q         <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
      rsp_err_q    <= rsp_err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;
  assign rsp_err    = rsp_err_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
